// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Each instruction steps through fetch, decode, execute, memory and writeback. The FSM drives the
// datapath mux selects, the write strobes and the 2-level alu_op. It stalls while memory is not
// ready, traps on undefined opcodes and on memory timeouts, and counts completed fetches.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   op                opcode IR[31:26], valid from DECODE onward
//   mem_ready         memory completes the current access this cycle
//   pc_write .. alu_op datapath strobes and selects (all forced to 0 while rst_n is low)
//   state             current state encoding, for debug
//   illegal           sticky: undefined opcode decoded
//   bus_error         sticky: memory wait limit exceeded
//   instr_count       completed fetches, wraps to 0 after all-ones
module multicycle_control #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WAIT_LIMIT = 255  // 0 disables the timeout
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    // Timeout fires on the cycle that would make the WAIT_LIMIT-th consecutive wait.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11,
        StTrap     = 4'd12
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               illegal_q, illegal_d;
    logic               bus_error_q, bus_error_d;

    logic       ctl_pc_write, ctl_pc_write_cond, ctl_i_or_d, ctl_mem_read, ctl_mem_write;
    logic       ctl_ir_write, ctl_reg_dst, ctl_mem_to_reg, ctl_reg_write, ctl_alu_src_a;
    logic [1:0] ctl_pc_source, ctl_alu_src_b;
    logic [2:0] ctl_alu_op;

    logic   mem_phase;  // current state waits on mem_ready
    state_e mem_next;   // where to go once the access completes
    logic   timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            wait_q      <= '0;
            count_q     <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            count_q     <= count_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        wait_d            = '0;
        count_d           = count_q;
        illegal_d         = illegal_q;
        bus_error_d       = bus_error_q;
        mem_phase         = 1'b0;
        mem_next          = StFetch;
        timeout           = (WAIT_LIMIT != 0) && (wait_q == WAIT_LAST);
        ctl_pc_write      = 1'b0;
        ctl_pc_write_cond = 1'b0;
        ctl_pc_source     = 2'b00;
        ctl_i_or_d        = 1'b0;
        ctl_mem_read      = 1'b0;
        ctl_mem_write     = 1'b0;
        ctl_ir_write      = 1'b0;
        ctl_reg_dst       = 1'b0;
        ctl_mem_to_reg    = 1'b0;
        ctl_reg_write     = 1'b0;
        ctl_alu_src_a     = 1'b0;
        ctl_alu_src_b     = 2'b00;
        ctl_alu_op        = 3'b000;

        case (state_q)
            StFetch: begin
                ctl_mem_read  = 1'b1;
                ctl_alu_src_b = 2'b01;
                mem_phase     = 1'b1;
                mem_next      = StDecode;
                // IR load and PC+4 are Mealy: only on the completing cycle.
                if (mem_ready) begin
                    ctl_ir_write = 1'b1;
                    ctl_pc_write = 1'b1;
                    count_d      = count_q + 1'b1;
                end
            end
            StDecode: begin
                ctl_alu_src_b = 2'b11;
                case (op)
                    OP_RTYPE:      state_d = StExecR;
                    OP_LW, OP_SW:  state_d = StMemAddr;
                    OP_BEQ:        state_d = StBranch;
                    OP_J:          state_d = StJump;
                    OP_ADDI:       state_d = StAddiExec;
                    default: begin
                        state_d   = StTrap;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAddr: begin
                ctl_alu_src_a = 1'b1;
                ctl_alu_src_b = 2'b10;
                state_d       = (op == OP_LW) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                ctl_mem_read = 1'b1;
                ctl_i_or_d   = 1'b1;
                mem_phase    = 1'b1;
                mem_next     = StMemWb;
            end
            StMemWb: begin
                ctl_reg_write  = 1'b1;
                ctl_mem_to_reg = 1'b1;
                state_d        = StFetch;
            end
            StMemWrite: begin
                ctl_mem_write = 1'b1;
                ctl_i_or_d    = 1'b1;
                mem_phase     = 1'b1;
                mem_next      = StFetch;
            end
            StExecR: begin
                ctl_alu_src_a = 1'b1;
                ctl_alu_op    = 3'b010;
                state_d       = StRWb;
            end
            StRWb: begin
                ctl_reg_write = 1'b1;
                ctl_reg_dst   = 1'b1;
                state_d       = StFetch;
            end
            StBranch: begin
                ctl_alu_src_a     = 1'b1;
                ctl_alu_op        = 3'b001;
                ctl_pc_write_cond = 1'b1;
                ctl_pc_source     = 2'b01;
                state_d           = StFetch;
            end
            StJump: begin
                ctl_pc_write  = 1'b1;
                ctl_pc_source = 2'b10;
                state_d       = StFetch;
            end
            StAddiExec: begin
                ctl_alu_src_a = 1'b1;
                ctl_alu_src_b = 2'b10;
                state_d       = StAddiWb;
            end
            StAddiWb: begin
                ctl_reg_write = 1'b1;
                state_d       = StFetch;
            end
            StTrap: state_d = StTrap;
            default: state_d = StTrap;
        endcase

        // Shared wait-state handling; completion wins over a simultaneous timeout.
        if (mem_phase) begin
            if (mem_ready) begin
                state_d = mem_next;
            end else if (timeout) begin
                state_d     = StTrap;
                bus_error_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    // Gate with rst_n so an asserted reset silences the datapath within the same cycle.
    assign pc_write      = rst_n & ctl_pc_write;
    assign pc_write_cond = rst_n & ctl_pc_write_cond;
    assign pc_source     = rst_n ? ctl_pc_source : 2'b00;
    assign i_or_d        = rst_n & ctl_i_or_d;
    assign mem_read      = rst_n & ctl_mem_read;
    assign mem_write     = rst_n & ctl_mem_write;
    assign ir_write      = rst_n & ctl_ir_write;
    assign reg_dst       = rst_n & ctl_reg_dst;
    assign mem_to_reg    = rst_n & ctl_mem_to_reg;
    assign reg_write     = rst_n & ctl_reg_write;
    assign alu_src_a     = rst_n & ctl_alu_src_a;
    assign alu_src_b     = rst_n ? ctl_alu_src_b : 2'b00;
    assign alu_op        = rst_n ? ctl_alu_op : 3'b000;
    assign state         = state_q;
    assign illegal       = illegal_q;
    assign bus_error     = bus_error_q;
    assign instr_count   = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (CNT_W=4, WAIT_LIMIT=4).
// Table-driven per-opcode walks, directed corner sequences, then randomized traffic against an
// instruction-level reference model (state paths per instruction class, wait/timeout counting).
module tb_multicycle_control;

    localparam int CW    = 4;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    op = 6'd0;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic          reg_dst, mem_to_reg, reg_write, alu_src_a, illegal, bus_error;
    logic [1:0]    pc_source, alu_src_b;
    logic [2:0]    alu_op;
    logic [3:0]    state;
    logic [CW-1:0] instr_count;
    logic [16:0]   ctrl;

    multicycle_control #(.CNT_W(CW), .WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .illegal(illegal), .bus_error(bus_error), .instr_count(instr_count)
    );

    assign ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected control word for a state; rdy only matters in FETCH.
    function automatic logic [16:0] exp_ctrl(input int s, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa;
        logic [1:0] ps, asb;
        logic [2:0] aop;
        {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa} = '0;
        ps = 2'b00; asb = 2'b00; aop = 3'b000;
        case (s)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 3'b010; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 3'b001; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, ps, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop};
    endfunction

    // Reference model: the current instruction's state path as nibbles, and position within it.
    logic [19:0] m_path;
    int          m_len, m_pos, m_wait, m_cnt;
    bit          m_ill, m_berr, m_trap;

    function automatic int m_cur();
        return m_trap ? 12 : int'(m_path[m_pos*4 +: 4]);
    endfunction

    task automatic model_reset();
        m_path = 20'h00010; m_len = 2; m_pos = 0; m_wait = 0; m_cnt = 0;
        m_ill = 0; m_berr = 0; m_trap = 0;
    endtask

    task automatic model_advance();
        m_pos++;
        if (m_pos >= m_len) begin
            m_path = 20'h00010; m_len = 2; m_pos = 0;
        end
    endtask

    task automatic model_step(input logic [5:0] o, input logic r);
        int s;
        if (m_trap) return;
        s = m_cur();
        if (s == 0 || s == 3 || s == 5) begin
            if (r) begin
                m_wait = 0;
                if (s == 0) m_cnt = (m_cnt + 1) % (1 << CW);
                model_advance();
            end else if (m_wait + 1 == LIMIT) begin
                m_trap = 1; m_berr = 1;
            end else begin
                m_wait++;
            end
        end else if (s == 1) begin
            case (o)
                6'b000000: begin m_path = 20'h07610; m_len = 4; end
                6'b001000: begin m_path = 20'h0BA10; m_len = 4; end
                6'b000100: begin m_path = 20'h00810; m_len = 3; end
                6'b000010: begin m_path = 20'h00910; m_len = 3; end
                6'b101011: begin m_path = 20'h05210; m_len = 4; end
                6'b100011: begin m_path = 20'h43210; m_len = 5; end
                default:   begin m_trap = 1; m_ill = 1; end
            endcase
            if (!m_trap) m_pos = 2;
            if (m_pos >= m_len) model_advance();
        end else begin
            model_advance();
        end
    endtask

    task automatic model_check(input string tag);
        check({tag, "_state"}, 32'(state), 32'(m_cur()));
        check({tag, "_ctrl"}, 32'(ctrl), 32'(exp_ctrl(m_cur(), mem_ready)));
        check({tag, "_illegal"}, 32'(illegal), 32'(m_ill));
        check({tag, "_berr"}, 32'(bus_error), 32'(m_berr));
        check({tag, "_count"}, 32'(instr_count), 32'(m_cnt));
    endtask

    // Cycle discipline: called at a negedge; inputs set, then sampled 1 ns later.
    task automatic set_in(input logic [5:0] o, input logic r);
        op = o; mem_ready = r; #1;
    endtask

    task automatic adv();
        @(posedge clk);
        model_step(op, mem_ready);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; #1;
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_flags", 32'({illegal, bus_error}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        string       name;
        logic [5:0]  opc;
        int          n;
        logic [19:0] st;     // expected state per cycle, nibble 0 first
        int          final_st;
    } vec_t;

    vec_t        vecs[7];
    logic [5:0]  legal_ops[6];
    int          n3, trap_cycles;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"rtype", 6'b000000, 4, 20'h07610, 0};
        vecs[1] = '{"addi",  6'b001000, 4, 20'h0BA10, 0};
        vecs[2] = '{"beq",   6'b000100, 3, 20'h00810, 0};
        vecs[3] = '{"j",     6'b000010, 3, 20'h00910, 0};
        vecs[4] = '{"sw",    6'b101011, 4, 20'h05210, 0};
        vecs[5] = '{"lw",    6'b100011, 5, 20'h43210, 0};
        vecs[6] = '{"undef", 6'b111111, 2, 20'h00010, 12};
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        model_reset();

        @(negedge clk);

        // Per-opcode walks with zero wait states.
        foreach (vecs[k]) begin
            do_reset();
            for (int i = 0; i < vecs[k].n; i++) begin
                set_in(vecs[k].opc, 1'b1);
                check({vecs[k].name, "_st"}, 32'(state), 32'(vecs[k].st[i*4 +: 4]));
                check({vecs[k].name, "_ctl"}, 32'(ctrl), 32'(exp_ctrl(int'(vecs[k].st[i*4 +: 4]), 1'b1)));
                adv();
            end
            set_in(vecs[k].opc, 1'b1);
            check({vecs[k].name, "_end"}, 32'(state), 32'(vecs[k].final_st));
            check({vecs[k].name, "_cnt"}, 32'(instr_count), 32'd1);
            check({vecs[k].name, "_ill"}, 32'(illegal), 32'(vecs[k].final_st == 12));
        end

        // lw with three wait cycles in MEM_READ.
        do_reset();
        n3 = 0;
        for (int c = 0; c < 8; c++) begin
            set_in(6'b100011, (c >= 3 && c <= 5) ? 1'b0 : 1'b1);
            model_check("lwwait");
            if (state == 4'd3) begin
                n3++;
                check("lwwait_mem_read", 32'(mem_read), 32'd1);
            end
            if (state == 4'd4) check("lwwait_m2r", 32'(mem_to_reg), 32'd1);
            adv();
        end
        set_in(6'b000000, 1'b0);
        check("lwwait_done", 32'(state), 32'd0);
        check("lwwait_held", 32'(n3), 32'd4);

        // beq, j, addi back to back.
        do_reset();
        foreach (vecs[k]) begin
            if (k >= 1 && k <= 3) begin
                for (int i = 0; i < vecs[k].n; i++) begin
                    set_in(vecs[k].opc, 1'b1);
                    model_check("b2b");
                    if (state == 4'd8) check("b2b_beq", 32'({pc_write_cond, pc_source, alu_op}),
                                             32'({1'b1, 2'b01, 3'b001}));
                    if (state == 4'd9) check("b2b_j", 32'({pc_write, pc_source}), 32'({1'b1, 2'b10}));
                    adv();
                end
            end
        end
        set_in(6'b000000, 1'b0);
        check("b2b_count", 32'(instr_count), 32'd3);

        // Undefined opcode: trap, silent for 20 cycles, reset recovers.
        do_reset();
        set_in(6'b111111, 1'b1); adv();
        set_in(6'b111111, 1'b1); adv();
        for (int i = 0; i < 20; i++) begin
            set_in(6'b000000, 1'b1);
            check("trap_state", 32'(state), 32'd12);
            check("trap_quiet", 32'(ctrl), 32'd0);
            check("trap_illegal", 32'(illegal), 32'd1);
            adv();
        end
        do_reset();

        // Fetch timeout after four wait cycles.
        for (int i = 0; i < 4; i++) begin
            set_in(6'b000000, 1'b0);
            check("tmo_fetch", 32'(state), 32'd0);
            adv();
        end
        set_in(6'b000000, 1'b0);
        check("tmo_state", 32'(state), 32'd12);
        check("tmo_berr", 32'(bus_error), 32'd1);
        do_reset();
        // Ready arriving on the fourth wait cycle completes the fetch.
        for (int i = 0; i < 4; i++) begin
            set_in(6'b000000, (i == 3) ? 1'b1 : 1'b0);
            adv();
        end
        set_in(6'b000000, 1'b0);
        check("edge_state", 32'(state), 32'd1);
        check("edge_berr", 32'(bus_error), 32'd0);
        check("edge_count", 32'(instr_count), 32'd1);

        // Asynchronous reset during MEM_WRITE.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(6'b101011, 1'b1); adv();
        end
        set_in(6'b101011, 1'b0);
        check("async_pre", 32'(mem_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_mw", 32'(mem_write), 32'd0);
        check("async_ctrl", 32'(ctrl), 32'd0);
        check("async_state", 32'(state), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_in(6'b000000, 1'b0);
        check("async_after", 32'(state), 32'd0);

        // Count wrap: fifteen jumps reach all-ones, the next fetch wraps to zero.
        do_reset();
        for (int n = 0; n < 15; n++) begin
            for (int i = 0; i < 3; i++) begin
                set_in(6'b000010, 1'b1); adv();
            end
        end
        set_in(6'b000010, 1'b0);
        check("wrap_full", 32'(instr_count), 32'hF);
        set_in(6'b000010, 1'b1); adv();
        set_in(6'b000010, 1'b1);
        check("wrap_zero", 32'(instr_count), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        trap_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_trap && trap_cycles >= 3) begin
                do_reset();
                trap_cycles = 0;
            end
            if (m_cur() == 0)
                op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
            set_in(op, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            model_check("rnd");
            if (m_trap) trap_cycles++;
            adv();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
